// File: rtl/router_out_arbiter.sv
// router_out_arbiter
// Per-output-port scheduler for the 2-VC mesh router. It shares one output
// channel between NREQ input requesters. Each virtual channel keeps its own
// round-robin pointer. The block also owns the occupancy flags of the two
// single-flit output buffers (even VC and odd VC) that feed the link. Only the
// VC selected by the mesh polarity phase is served in a given cycle.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-high reset
//   polarity   - mesh phase: 0 serves the even VC, 1 serves the odd VC
//   req_even   - per-input requests holding an even-VC flit for this output
//   req_odd    - per-input requests holding an odd-VC flit for this output
//   drain_even - downstream consumed the even output buffer this cycle
//   drain_odd  - downstream consumed the odd output buffer this cycle
//   gnt        - one-hot grant; the winner's flit is written at the next edge
//   gnt_valid  - OR of gnt
//   gnt_vc     - VC of the current grant (follows polarity outside reset)
//   full_even  - even output buffer occupied
//   full_odd   - odd output buffer occupied
module router_out_arbiter #(
  parameter int NREQ = 5,
  parameter int PTRW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            polarity,
  input  logic [NREQ-1:0] req_even,
  input  logic [NREQ-1:0] req_odd,
  input  logic            drain_even,
  input  logic            drain_odd,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic            gnt_vc,
  output logic            full_even,
  output logic            full_odd
);

  logic [PTRW-1:0] ptrEven_q, ptrEven_d;
  logic [PTRW-1:0] ptrOdd_q, ptrOdd_d;
  logic            fullEven_q, fullEven_d;
  logic            fullOdd_q, fullOdd_d;

  logic [NREQ-1:0] reqAct;
  logic [PTRW-1:0] ptrAct;
  logic [PTRW-1:0] winner;
  logic [PTRW-1:0] ptrNext;
  logic            found;
  logic            space;
  logic            grantOk;
  logic [NREQ-1:0] gntVec;
  int              scanIdx;

  // Grant selection for the active VC. The scan starts at that VC's pointer
  // and wraps explicitly at NREQ, because NREQ need not be a power of two.
  // A drain in the same cycle frees the buffer slot, which allows back-to-back
  // grants into a single-flit buffer.
  always_comb begin
    reqAct  = polarity ? req_odd : req_even;
    ptrAct  = polarity ? ptrOdd_q : ptrEven_q;
    space   = polarity ? (!fullOdd_q || drain_odd) : (!fullEven_q || drain_even);
    found   = 1'b0;
    winner  = '0;
    scanIdx = 0;
    for (int off = 0; off < NREQ; off++) begin
      scanIdx = int'(ptrAct) + off;
      if (scanIdx >= NREQ) begin
        scanIdx = scanIdx - NREQ;
      end
      if (!found && reqAct[scanIdx[PTRW-1:0]]) begin
        found  = 1'b1;
        winner = scanIdx[PTRW-1:0];
      end
    end
    grantOk = !reset && space && found;
    gntVec  = '0;
    if (grantOk) begin
      gntVec[winner] = 1'b1;
    end
    ptrNext = (winner == PTRW'(NREQ - 1)) ? '0 : winner + 1'b1;
  end

  // Next-state computation. Only the active VC can advance its pointer or set
  // its full flag. Either VC's full flag can be cleared by its own drain at
  // any time. When a grant and a drain coincide, the grant wins and the slot
  // stays occupied.
  always_comb begin
    ptrEven_d  = ptrEven_q;
    ptrOdd_d   = ptrOdd_q;
    fullEven_d = fullEven_q;
    fullOdd_d  = fullOdd_q;
    if (drain_even) begin
      fullEven_d = 1'b0;
    end
    if (drain_odd) begin
      fullOdd_d = 1'b0;
    end
    if (grantOk) begin
      if (polarity) begin
        ptrOdd_d  = ptrNext;
        fullOdd_d = 1'b1;
      end else begin
        ptrEven_d  = ptrNext;
        fullEven_d = 1'b1;
      end
    end
  end

  // State registers. Reset clears the occupancy flags without flushing the
  // buffers, so any flit held in them at reset time is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptrEven_q  <= '0;
      ptrOdd_q   <= '0;
      fullEven_q <= 1'b0;
      fullOdd_q  <= 1'b0;
    end else begin
      ptrEven_q  <= ptrEven_d;
      ptrOdd_q   <= ptrOdd_d;
      fullEven_q <= fullEven_d;
      fullOdd_q  <= fullOdd_d;
    end
  end

  assign gnt       = gntVec;
  assign gnt_valid = grantOk;
  assign gnt_vc    = !reset && polarity;
  assign full_even = fullEven_q;
  assign full_odd  = fullOdd_q;

endmodule

// File: tb/tb_router_out_arbiter.sv
// tb_router_out_arbiter
// The bench runs in two parts.
// The first part is a table of directed vectors covering the basic scenarios
// and the multi-cycle corners.
// The second part applies random traffic and compares it with a reference
// model of the arbiter's rules.
module tb_router_out_arbiter;

  localparam int NREQ = 5;

  logic            clk;
  logic            reset;
  logic            polarity;
  logic [NREQ-1:0] req_even;
  logic [NREQ-1:0] req_odd;
  logic            drain_even;
  logic            drain_odd;
  logic [NREQ-1:0] gnt;
  logic            gnt_valid;
  logic            gnt_vc;
  logic            full_even;
  logic            full_odd;

  int assertCount;
  int failCount;

  typedef struct {
    logic            rst;
    logic            pol;
    logic [NREQ-1:0] reqE;
    logic [NREQ-1:0] reqO;
    logic            drE;
    logic            drO;
    logic [NREQ-1:0] expGnt;
    logic            expFullE;
    logic            expFullO;
  } vec_t;

  vec_t vecs[$];

  router_out_arbiter #(.NREQ(NREQ), .PTRW(3)) dut (
    .clk(clk),
    .reset(reset),
    .polarity(polarity),
    .req_even(req_even),
    .req_odd(req_odd),
    .drain_even(drain_even),
    .drain_odd(drain_odd),
    .gnt(gnt),
    .gnt_valid(gnt_valid),
    .gnt_vc(gnt_vc),
    .full_even(full_even),
    .full_odd(full_odd)
  );

  // The clock has a period of 10 time units.
  // Inputs change on the falling edge.
  // Outputs are sampled 2 units later, well before the next rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value and records the
  // result.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs on the falling edge and waits for the
  // combinational grant to settle.
  task automatic applyStimulus(input logic rst, input logic pol,
                               input logic [NREQ-1:0] rE, input logic [NREQ-1:0] rO,
                               input logic dE, input logic dO);
    @(negedge clk);
    reset      = rst;
    polarity   = pol;
    req_even   = rE;
    req_odd    = rO;
    drain_even = dE;
    drain_odd  = dO;
    #2;
  endtask

  function automatic vec_t mk(input logic rst, input logic pol,
                              input logic [NREQ-1:0] rE, input logic [NREQ-1:0] rO,
                              input logic dE, input logic dO,
                              input logic [NREQ-1:0] g, input logic fE, input logic fO);
    vec_t v;
    v.rst = rst; v.pol = pol; v.reqE = rE; v.reqO = rO; v.drE = dE; v.drO = dO;
    v.expGnt = g; v.expFullE = fE; v.expFullO = fO;
    return v;
  endfunction

  // The reference model scans the request vector from pointer p in modular
  // order and returns the index of the first requester found, or -1 if none.
  function automatic int modelWinner(input int p, input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  int              mPtr[2];
  logic            mFull[2];

  initial begin
    assertCount = 0;
    failCount   = 0;

    // Directed vectors. The full flags in each row are the state entering that
    // cycle, before its rising edge.
    // Basic round robin with drain pulsed every cycle.
    vecs.push_back(mk(1, 0, 5'b00000, 5'b00000, 0, 0, 5'b00000, 0, 0));
    vecs.push_back(mk(0, 0, 5'b10110, 5'b00000, 1, 0, 5'b00010, 0, 0));
    vecs.push_back(mk(0, 0, 5'b10110, 5'b00000, 1, 0, 5'b00100, 1, 0));
    vecs.push_back(mk(0, 0, 5'b10110, 5'b00000, 1, 0, 5'b10000, 1, 0));
    vecs.push_back(mk(0, 0, 5'b10110, 5'b00000, 1, 0, 5'b00010, 1, 0));
    // Blocking while the buffer is full, then a grant on the drain cycle.
    vecs.push_back(mk(0, 0, 5'b00000, 5'b00000, 1, 0, 5'b00000, 1, 0));
    vecs.push_back(mk(0, 0, 5'b00001, 5'b00000, 0, 0, 5'b00001, 0, 0));
    vecs.push_back(mk(0, 0, 5'b00001, 5'b00000, 0, 0, 5'b00000, 1, 0));
    vecs.push_back(mk(0, 0, 5'b00001, 5'b00000, 0, 0, 5'b00000, 1, 0));
    vecs.push_back(mk(0, 0, 5'b00001, 5'b00000, 1, 0, 5'b00001, 1, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 5'b00000, 1, 0, 5'b00000, 1, 0));
    // Polarity alternating, with independent pointers per VC.
    vecs.push_back(mk(1, 0, 5'b00000, 5'b00000, 0, 0, 5'b00000, 0, 0));
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk(0, 0, 5'b00011, 5'b11000, 1, 1, (i % 2 == 0) ? 5'b00001 : 5'b00010, 0, i > 0));
      vecs.push_back(mk(0, 1, 5'b00011, 5'b11000, 1, 1, (i % 2 == 0) ? 5'b01000 : 5'b10000, 1, 0));
    end
    // Odd buffer full, so there is no grant. Even requests are ignored in the
    // odd phase.
    vecs.push_back(mk(0, 1, 5'b00100, 5'b00100, 0, 0, 5'b00000, 0, 1));
    vecs.push_back(mk(0, 1, 5'b00100, 5'b00100, 0, 0, 5'b00000, 0, 1));
    vecs.push_back(mk(0, 1, 5'b00100, 5'b00100, 0, 1, 5'b00100, 0, 1));
    // Reset in the middle of traffic with both buffers full.
    vecs.push_back(mk(0, 0, 5'b00100, 5'b00000, 0, 0, 5'b00100, 0, 1));
    vecs.push_back(mk(1, 0, 5'b11111, 5'b11111, 0, 0, 5'b00000, 1, 1));
    vecs.push_back(mk(0, 0, 5'b11111, 5'b00000, 0, 0, 5'b00001, 0, 0));
    // Drain in the inactive phase, then a drain while the buffer is empty.
    vecs.push_back(mk(0, 1, 5'b00000, 5'b00000, 1, 0, 5'b00000, 1, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 5'b00000, 1, 0, 5'b00000, 0, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 5'b00000, 0, 0, 5'b00000, 0, 0));
    vecs.push_back(mk(0, 0, 5'b11111, 5'b00000, 0, 0, 5'b00010, 0, 0));

    // Hold reset for two edges before the table so that all state is known.
    applyStimulus(1, 0, '0, '0, 0, 0);
    applyStimulus(1, 0, '0, '0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].pol, vecs[i].reqE, vecs[i].reqO, vecs[i].drE, vecs[i].drO);
      checkOutput($sformatf("vec%0d gnt", i), 32'(gnt), 32'(vecs[i].expGnt));
      checkOutput($sformatf("vec%0d gnt_valid", i), 32'(gnt_valid), 32'(vecs[i].expGnt != 0));
      if (vecs[i].rst || vecs[i].expGnt != 0)
        checkOutput($sformatf("vec%0d gnt_vc", i), 32'(gnt_vc), 32'(vecs[i].rst ? 1'b0 : vecs[i].pol));
      checkOutput($sformatf("vec%0d full_even", i), 32'(full_even), 32'(vecs[i].expFullE));
      checkOutput($sformatf("vec%0d full_odd", i), 32'(full_odd), 32'(vecs[i].expFullO));
    end

    // Random traffic checked against the reference model.
    applyStimulus(1, 0, '0, '0, 0, 0);
    mPtr[0] = 0; mPtr[1] = 0; mFull[0] = 0; mFull[1] = 0;
    begin
      logic            rst, pol, dE, dO;
      logic [NREQ-1:0] rE, rO, rAct, expG;
      logic            dr[2];
      int              v, w;
      pol = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        rst = ($urandom_range(0, 39) == 0);
        pol = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : ~pol;
        rE  = NREQ'($urandom_range(0, 31));
        rO  = NREQ'($urandom_range(0, 31));
        dE  = ($urandom_range(0, 2) == 0);
        dO  = ($urandom_range(0, 2) == 0);
        applyStimulus(rst, pol, rE, rO, dE, dO);

        v     = pol ? 1 : 0;
        rAct  = pol ? rO : rE;
        dr[0] = dE;
        dr[1] = dO;
        w     = -1;
        if (!rst && (!mFull[v] || dr[v])) w = modelWinner(mPtr[v], rAct);
        expG = '0;
        if (w >= 0) expG[w] = 1'b1;

        checkOutput($sformatf("rnd%0d gnt", cyc), 32'(gnt), 32'(expG));
        checkOutput($sformatf("rnd%0d gnt_valid", cyc), 32'(gnt_valid), 32'(w >= 0));
        if (rst || w >= 0)
          checkOutput($sformatf("rnd%0d gnt_vc", cyc), 32'(gnt_vc), 32'(rst ? 1'b0 : pol));
        checkOutput($sformatf("rnd%0d full_even", cyc), 32'(full_even), 32'(mFull[0]));
        checkOutput($sformatf("rnd%0d full_odd", cyc), 32'(full_odd), 32'(mFull[1]));

        // Apply the effect of the coming rising edge to the model.
        if (rst) begin
          mPtr[0] = 0; mPtr[1] = 0; mFull[0] = 0; mFull[1] = 0;
        end else begin
          for (int c = 0; c < 2; c++) begin
            if (dr[c]) mFull[c] = 1'b0;
          end
          if (w >= 0) begin
            mFull[v] = 1'b1;
            mPtr[v]  = (w + 1) % NREQ;
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/router_out_arbiter.md
Name: router_out_arbiter

Overview:
- Per-output-port scheduler for the 2-VC mesh router. Shares one output channel between NREQ input requesters.
- Keeps one round-robin pointer per virtual channel (even VC = flit bit 63 clear, odd VC = bit 63 set).
- Owns the occupancy flags of the two single-flit output buffers, even and odd, that feed the link.
- Serves only the VC selected by the mesh polarity phase. Instantiated once per output direction (N, E, S, W, PE) in each router.

Parameters:
NREQ, 5, number of requesting input ports (index 0=N, 1=E, 2=S, 3=W, 4=PE)
PTRW, 3, width of each round-robin pointer (ceil(log2(NREQ)), min 1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
polarity  input  1  mesh phase; 0 = even-VC internal phase, 1 = odd-VC internal phase
req_even  input  NREQ  bit i: input i holds an even-VC flit routed to this output
req_odd  input  NREQ  bit i: input i holds an odd-VC flit routed to this output
drain_even  input  1  downstream consumed even output buffer this cycle
drain_odd  input  1  downstream consumed odd output buffer this cycle
gnt  output  NREQ  one-hot grant; winner's flit is written to the output buffer at next rising edge
gnt_valid  output  1  OR of gnt
gnt_vc  output  1  VC of current grant (equals polarity when gnt_valid)
full_even  output  1  even output buffer occupied
full_odd  output  1  odd output buffer occupied

Behaviour:
- One clock; reset is synchronous and active-high.
- Registered state: ptr_even, ptr_odd (PTRW bits each), full_even, full_odd.
- Reset (sampled at posedge): ptr_even=ptr_odd=0, full_even=full_odd=0.
- While reset is high, gnt=0, gnt_valid=0 and gnt_vc=0, combinationally. Reset mid-traffic discards buffered occupancy with no flush.
- Active VC v = polarity. Active request vector R = polarity ? req_odd : req_even. Requests of the inactive VC are ignored this cycle.
- Space available: space = !full_v || drain_v. A same-cycle drain frees the slot, so back-to-back grants are allowed.
- Grant (combinational from registered state and current inputs):
  - If space and R != 0: gnt = one-hot of the first set bit of R scanning ptr_v, ptr_v+1, ..., wrapping modulo NREQ.
  - Otherwise gnt = 0.
  - Zero latency: request seen in cycle t gives grant in cycle t.
- Pointer update at posedge, only when gnt_valid: ptr_v <= (winner+1) mod NREQ. The inactive VC pointer holds.
- full_v update at posedge:
  - grant only: set to 1.
  - drain only: clear to 0.
  - grant and drain together: stays 1.
  - neither: holds.
- full of the inactive VC updates only from its drain input. Drain of the inactive VC is legal in any phase.
- Drain while not full is ignored (flag stays 0); verification flags it as a protocol warning.
- Requesters hold req until granted. A dropped request before grant is legal and is not remembered.
- Pointer values >= NREQ cannot be reached; the wrap is explicit when NREQ is not a power of 2.
- Fairness: under continuous requests from k inputs on one VC, each is granted exactly once every k grants of that VC.
- Polarity toggling every cycle (normal mesh operation): each VC gets at most one grant per 2 cycles.

Test Plan:
1. Reset, then polarity=0, req_even=5'b10110, drain_even pulsed every cycle -> grants on successive even cycles 5'b00010, 5'b00100, 5'b10000, 5'b00010; ptr_even 0->2->3->0->2.
2. polarity=0, req_even=5'b00001, no drain -> cycle 1 gnt=5'b00001 and full_even=1; cycles 2+ gnt=0 until drain_even=1; in the drain cycle, gnt=5'b00001 and full_even stays 1.
3. polarity alternates 0/1, req_even=5'b00011, req_odd=5'b11000, both drains held 1 -> even phases grant 0,1,0,1; odd phases grant 3,4,3,4; gnt_vc tracks polarity; pointers independent.
4. full_odd=1, polarity=1, req_odd=5'b00100, drain_odd=0 -> gnt=0; same cycle req_even=5'b00100 produces no grant (inactive VC); ptr_odd unchanged.
5. Mid-traffic with full_even=1, full_odd=1, ptr_even=3: assert reset for one cycle -> gnt=0 during reset; after, full_*=0 and ptr_*=0; first request 5'b11111 grants index 0.
6. drain_even=1 while full_even=0 and req_even=0 -> full_even stays 0, no grant, ptr unchanged.
